// File: rtl/recip_pkg.sv
// =============================================================================
// Module : recip_pkg
// Brief  : Shared widths and request/response records for the reciprocal seed fetch.
//          Optional feature macro: DIVZERO_FLAG_EN (adds the dz field).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package recip_pkg;

  localparam int XLEN    = 32;
  localparam int IDX_W   = 9;
  localparam int SEED_W  = 19;
  localparam int TAG_W   = 5;
  localparam int SHAMT_W = $clog2(XLEN) + 1;

  typedef struct packed {
    logic [XLEN-1:0]  div;
    logic [TAG_W-1:0] tag;
  } seed_req_t;

  typedef struct packed {
    logic [SEED_W-1:0]  seed;
    logic [XLEN-1:0]    norm;
    logic [SHAMT_W-1:0] shamt;
    logic [TAG_W-1:0]   tag;
`ifdef DIVZERO_FLAG_EN
    logic               dz;
`endif
  } seed_rsp_t;

endpackage

`default_nettype wire

// File: rtl/recip_seed_fetch_lzc32.sv
// =============================================================================
// Module : lzc32
// Brief  : Combinational leading-zero counter, result 0..32 (32 for an all-zero input).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module lzc32 (
  input  logic [31:0] din,
  output logic [5:0]  count
);

  // Scanning upward lets the most significant set bit have the final say.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (din[i]) count = 6'(31 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/recip_seed_fetch.sv
// =============================================================================
// Module : recip_seed_fetch
// Brief  : Three-stage divisor normalise / seed-table lookup front end with valid/ready.
//          Optional feature macro: DIVZERO_FLAG_EN (out_dz port, forced all-ones seed).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module recip_seed_fetch
  import recip_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_div,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [IDX_W-1:0]   tbl_index,
  input  logic [SEED_W-1:0]  tbl_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEED_W-1:0]  out_seed,
  output logic [XLEN-1:0]    out_norm,
  output logic [SHAMT_W-1:0] out_shamt,
`ifdef DIVZERO_FLAG_EN
  output logic               out_dz,
`endif
  output logic [TAG_W-1:0]   out_tag
);

  logic               v1, v2, v3;
  logic               adv1, adv2, adv3;
  logic               accept;
  seed_req_t          s1;
  logic [XLEN-1:0]    norm2;
  logic [SHAMT_W-1:0] shamt2;
  logic [TAG_W-1:0]   tag2;
  seed_rsp_t          s3;
  seed_rsp_t          rsp_next;
  logic [SHAMT_W-1:0] lzc;
  logic [XLEN-1:0]    norm1;

  assign adv3     = v3 & out_ready;
  assign adv2     = v2 & (~v3 | adv3);
  assign adv1     = v1 & (~v2 | adv2);
  assign in_ready = ~v1 | adv1;
  assign accept   = in_valid & in_ready;

  lzc32 u_lzc (
    .din   (s1.div),
    .count (lzc)
  );

  // A shift by the full width yields zero, so divisor 0 normalises to 0.
  assign norm1 = s1.div << lzc;

  // The leading one is implicit; the index is the next IDX_W bits below it.
  assign tbl_index = norm2[XLEN-2 -: IDX_W];

  always_comb begin
    rsp_next       = '0;
    rsp_next.norm  = norm2;
    rsp_next.shamt = shamt2;
    rsp_next.tag   = tag2;
`ifdef DIVZERO_FLAG_EN
    rsp_next.dz    = (shamt2 == SHAMT_W'(XLEN));
    rsp_next.seed  = rsp_next.dz ? '1 : tbl_word;
`else
    rsp_next.seed  = tbl_word;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1     <= '0;
      norm2  <= '0;
      shamt2 <= '0;
      tag2   <= '0;
      s3     <= '0;
    end else begin
      v1 <= accept | (v1 & ~adv1);
      v2 <= adv1   | (v2 & ~adv2);
      v3 <= adv2   | (v3 & ~adv3);
      if (accept) begin
        s1.div <= in_div;
        s1.tag <= in_tag;
      end
      if (adv1) begin
        norm2  <= norm1;
        shamt2 <= lzc;
        tag2   <= s1.tag;
      end
      // tbl_word is only sampled when stage 2 holds a real entry.
      if (adv2) begin
        s3 <= rsp_next;
      end
    end
  end

  assign out_valid = v3;
  assign out_seed  = s3.seed;
  assign out_norm  = s3.norm;
  assign out_shamt = s3.shamt;
  assign out_tag   = s3.tag;
`ifdef DIVZERO_FLAG_EN
  assign out_dz    = s3.dz;
`endif

endmodule

`default_nettype wire

// File: tb/tb_recip_seed_fetch.sv
// =============================================================================
// Module : tb_recip_seed_fetch
// Brief  : Directed self-checking bench for recip_seed_fetch (honours DIVZERO_FLAG_EN).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_recip_seed_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_div;
  logic [4:0]  in_tag;
  logic [8:0]  tbl_index;
  logic [18:0] tbl_word;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_seed;
  logic [31:0] out_norm;
  logic [5:0]  out_shamt;
  logic [4:0]  out_tag;
`ifdef DIVZERO_FLAG_EN
  logic        out_dz;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign tbl_word = {10'b0, tbl_index} ^ 19'h2A5A5;

  recip_seed_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_div    (in_div),
    .in_tag    (in_tag),
    .tbl_index (tbl_index),
    .tbl_word  (tbl_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_seed  (out_seed),
    .out_norm  (out_norm),
    .out_shamt (out_shamt),
`ifdef DIVZERO_FLAG_EN
    .out_dz    (out_dz),
`endif
    .out_tag   (out_tag)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_div = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (tbl_index !== 9'd0) begin errors++; $display("FAIL reset_index got=%h exp=0", tbl_index); end
    checks++; if (out_seed !== 19'd0) begin errors++; $display("FAIL reset_seed got=%h exp=0", out_seed); end
    checks++; if (out_norm !== 32'd0) begin errors++; $display("FAIL reset_norm got=%h exp=0", out_norm); end
    checks++; if (out_shamt !== 6'd0 || out_tag !== 5'd0) begin
      errors++; $display("FAIL reset_shamt_tag got=%0d/%0d exp=0/0", out_shamt, out_tag);
    end
`ifdef DIVZERO_FLAG_EN
    checks++; if (out_dz !== 1'b0) begin errors++; $display("FAIL reset_dz got=%0b exp=0", out_dz); end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single(input logic [31:0] div, input logic [4:0] tag, input logic [5:0] e_shamt,
                             input logic [31:0] e_norm, input logic [8:0] e_idx, input logic [18:0] e_seed);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_div = div; in_tag = tag;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready div=%h got=%0b exp=1", div, in_ready); end
    @(negedge clk);
    in_valid = 1'b0; in_div = '0; in_tag = '0;
    @(negedge clk);
    checks++; if (tbl_index !== e_idx) begin errors++; $display("FAIL single_index div=%h got=%h exp=%h", div, tbl_index, e_idx); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency div=%h got=%0b exp=1", div, out_valid); end
    checks++; if (out_seed !== e_seed) begin errors++; $display("FAIL single_seed div=%h got=%h exp=%h", div, out_seed, e_seed); end
    checks++; if (out_norm !== e_norm) begin errors++; $display("FAIL single_norm div=%h got=%h exp=%h", div, out_norm, e_norm); end
    checks++; if (out_shamt !== e_shamt) begin errors++; $display("FAIL single_shamt div=%h got=%0d exp=%0d", div, out_shamt, e_shamt); end
    checks++; if (out_tag !== tag) begin errors++; $display("FAIL single_tag div=%h got=%0d exp=%0d", div, out_tag, tag); end
`ifdef DIVZERO_FLAG_EN
    checks++; if (out_dz !== (div == 32'd0)) begin errors++; $display("FAIL single_dz div=%h got=%0b exp=%0b", div, out_dz, (div == 32'd0)); end
`endif
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain div=%h got=%0b exp=0", div, out_valid); end
  endtask

  task automatic test_backpressure();
    int   exp_sh [1:4] = '{31, 30, 30, 29};
    int   next_in  = 1;
    int   next_out = 1;
    int   last_cyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      #1;
      if (out_valid && out_ready && next_out <= 4) begin
        checks++; if (out_tag !== 5'(next_out)) begin errors++; $display("FAIL bp_order got=%0d exp=%0d", out_tag, next_out); end
        checks++; if (out_shamt !== 6'(exp_sh[next_out])) begin
          errors++; $display("FAIL bp_shamt tag=%0d got=%0d exp=%0d", next_out, out_shamt, exp_sh[next_out]);
        end
        if (last_cyc >= 0) begin
          checks++; if (cyc != last_cyc + 1) begin errors++; $display("FAIL bp_rate got_cycle=%0d exp_cycle=%0d", cyc, last_cyc + 1); end
        end
        last_cyc = cyc;
        next_out++;
      end
      if (cyc == 3 || cyc == 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full cyc=%0d got=%0b exp=0", cyc, in_ready); end
      end
      if (next_in <= 4) begin
        in_valid = 1'b1; in_div = 32'(next_in); in_tag = 5'(next_in);
        if (in_ready) next_in++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++; if (next_out != 5) begin errors++; $display("FAIL bp_count got=%0d exp=4", next_out - 1); end
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_div = 32'd5; in_tag = 5'd7;
    @(negedge clk);
    in_div = 32'd6; in_tag = 5'd8;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstf_pre got=%0b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstf_async_valid got=%0b exp=0", out_valid); end
    checks++; if (tbl_index !== 9'd0 || out_tag !== 5'd0) begin
      errors++; $display("FAIL rstf_async_clear got=%h/%0d exp=0/0", tbl_index, out_tag);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstf_ghost got=%0d exp=0", seen); end
    test_single(32'h0000_0010, 5'd9, 6'd27, 32'h8000_0000, 9'h000, 19'h2A5A5);
  endtask

  initial begin
    test_reset();
    test_single(32'h0000_0001, 5'd3,  6'd31, 32'h8000_0000, 9'h000, 19'h2A5A5);
    test_single(32'hFFFF_FFFF, 5'd17, 6'd0,  32'hFFFF_FFFF, 9'h1FF, 19'h2A45A);
    test_single(32'h0003_0000, 5'd30, 6'd14, 32'hC000_0000, 9'h100, 19'h2A4A5);
    test_single(32'h1234_5678, 5'd11, 6'd3,  32'h91A2_B3C0, 9'h046, 19'h2A5E3);
`ifdef DIVZERO_FLAG_EN
    test_single(32'h0000_0000, 5'd21, 6'd32, 32'h0000_0000, 9'h000, 19'h7FFFF);
`else
    test_single(32'h0000_0000, 5'd21, 6'd32, 32'h0000_0000, 9'h000, 19'h2A5A5);
`endif
    test_backpressure();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
